// File: rtl/reg_bank_arbiter_if.sv
// reg_bank_arbiter_if
// Bundles every non-clock, non-reset signal around the register-bank arbiter.
// This covers the two requester ports (m0_*, m1_*), the arbiter status
// (gnt, busy), the enable and the bank-side access port (rb_*).
//   slave  : view taken by the arbiter (requests/bank replies in, results/strobes out)
//   master : view taken by whatever drives the arbiter (requesters + bank)
interface reg_bank_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int REG_W  = 8
);
  logic              ena;

  logic              m0_req;
  logic              m0_wr_rdn;
  logic [ADDR_W-1:0] m0_addr;
  logic [REG_W-1:0]  m0_wdata;
  logic              m0_done;
  logic [REG_W-1:0]  m0_rdata;
  logic              m0_err;

  logic              m1_req;
  logic              m1_wr_rdn;
  logic [ADDR_W-1:0] m1_addr;
  logic [REG_W-1:0]  m1_wdata;
  logic              m1_done;
  logic [REG_W-1:0]  m1_rdata;
  logic              m1_err;

  logic [1:0]        gnt;
  logic              busy;

  logic              rb_wr_rdn;
  logic [ADDR_W-1:0] rb_addr;
  logic [REG_W-1:0]  rb_wdata;
  logic              rb_we;
  logic [REG_W-1:0]  rb_rdata;
  logic              rb_ack;
  logic              rb_err;

  modport slave (
    input  ena,
    input  m0_req, m0_wr_rdn, m0_addr, m0_wdata,
    output m0_done, m0_rdata, m0_err,
    input  m1_req, m1_wr_rdn, m1_addr, m1_wdata,
    output m1_done, m1_rdata, m1_err,
    output gnt, busy,
    output rb_wr_rdn, rb_addr, rb_wdata, rb_we,
    input  rb_rdata, rb_ack, rb_err
  );

  modport master (
    output ena,
    output m0_req, m0_wr_rdn, m0_addr, m0_wdata,
    input  m0_done, m0_rdata, m0_err,
    output m1_req, m1_wr_rdn, m1_addr, m1_wdata,
    input  m1_done, m1_rdata, m1_err,
    input  gnt, busy,
    input  rb_wr_rdn, rb_addr, rb_wdata, rb_we,
    output rb_rdata, rb_ack, rb_err
  );
endinterface

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter
// Shares one register-bank access port between two requesters using two-way
// round-robin arbitration, one transaction at a time. The winning request is
// latched onto rb_*, and rb_we is held until rb_ack arrives or TIMEOUT cycles
// pass. The result then comes back with a one-cycle done pulse to the owner.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : reg_bank_arbiter_if.slave.
//              The interface carries ena, m0_*/m1_* (requests, done, rdata
//              and err), gnt, busy and rb_*.
// All outputs are registered.
module reg_bank_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int REG_W   = 8,
  parameter int TIMEOUT = 15   // 1..255
) (
  input  logic                clk,
  input  logic                rst,
  reg_bank_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t            state_reg;
  logic              last_gnt_reg;
  logic              owner_reg;
  logic [7:0]        cnt_reg;
  logic [1:0]        gnt_reg;
  logic              busy_reg;
  logic              rb_we_reg;
  logic              rb_wr_rdn_reg;
  logic [ADDR_W-1:0] rb_addr_reg;
  logic [REG_W-1:0]  rb_wdata_reg;
  logic [1:0]        done_reg;
  logic [1:0]        err_reg;
  logic [REG_W-1:0]  rdata_reg [2];

  // Requester inputs gathered into index-by-master form.
  logic [1:0]        req;
  logic [1:0]        wr_rdn;
  logic [ADDR_W-1:0] addr  [2];
  logic [REG_W-1:0]  wdata [2];

  assign req      = {bus.m1_req, bus.m0_req};
  assign wr_rdn   = {bus.m1_wr_rdn, bus.m0_wr_rdn};
  assign addr[0]  = bus.m0_addr;
  assign addr[1]  = bus.m1_addr;
  assign wdata[0] = bus.m0_wdata;
  assign wdata[1] = bus.m1_wdata;

  // Master 1 wins when it is the only requester, or when both request and
  // master 0 had the previous grant.
  logic       win;
  logic [7:0] cnt_inc;

  assign win     = req[1] & (~req[0] | ~last_gnt_reg);
  assign cnt_inc = cnt_reg + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      last_gnt_reg  <= 1'b1;
      owner_reg     <= 1'b0;
      cnt_reg       <= 8'd0;
      gnt_reg       <= 2'b00;
      busy_reg      <= 1'b0;
      rb_we_reg     <= 1'b0;
      rb_wr_rdn_reg <= 1'b0;
      rb_addr_reg   <= '0;
      rb_wdata_reg  <= '0;
      done_reg      <= 2'b00;
      err_reg       <= 2'b00;
      rdata_reg[0]  <= '0;
      rdata_reg[1]  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.ena && (|req)) begin
            owner_reg     <= win;
            gnt_reg       <= win ? 2'b10 : 2'b01;
            busy_reg      <= 1'b1;
            rb_we_reg     <= 1'b1;
            rb_wr_rdn_reg <= wr_rdn[win];
            rb_addr_reg   <= addr[win];
            rb_wdata_reg  <= wdata[win];
            cnt_reg       <= 8'd0;
            state_reg     <= ACCESS;
          end
        end

        ACCESS: begin
          // An ack in the same cycle the count expires still counts as a
          // normal completion, so it is tested first.
          if (bus.rb_ack) begin
            rb_we_reg            <= 1'b0;
            done_reg[owner_reg]  <= 1'b1;
            err_reg[owner_reg]   <= bus.rb_err;
            rdata_reg[owner_reg] <= rb_wr_rdn_reg ? '0 : bus.rb_rdata;
            state_reg            <= RESP;
          end else begin
            cnt_reg <= cnt_inc;
            if (cnt_inc == TIMEOUT_C) begin
              rb_we_reg            <= 1'b0;
              done_reg[owner_reg]  <= 1'b1;
              err_reg[owner_reg]   <= 1'b1;
              rdata_reg[owner_reg] <= '0;
              state_reg            <= RESP;
            end
          end
        end

        RESP: begin
          done_reg     <= 2'b00;
          last_gnt_reg <= owner_reg;
          cnt_reg      <= 8'd0;
          gnt_reg      <= 2'b00;
          busy_reg     <= 1'b0;
          state_reg    <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_reg;
  assign bus.busy      = busy_reg;
  assign bus.rb_we     = rb_we_reg;
  assign bus.rb_wr_rdn = rb_wr_rdn_reg;
  assign bus.rb_addr   = rb_addr_reg;
  assign bus.rb_wdata  = rb_wdata_reg;
  assign bus.m0_done   = done_reg[0];
  assign bus.m0_err    = err_reg[0];
  assign bus.m0_rdata  = rdata_reg[0];
  assign bus.m1_done   = done_reg[1];
  assign bus.m1_err    = err_reg[1];
  assign bus.m1_rdata  = rdata_reg[1];

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter
// Randomized bench for reg_bank_arbiter. Each cycle, the expected outputs come
// from a transaction-level reference model, and all outputs are compared.
// The model records each grant as (grant edge, number of strobe cycles,
// owner) and derives every later cycle from those numbers with plain
// arithmetic. A memory array plays the register bank.
module tb_reg_bank_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_bank_arbiter_if #(.ADDR_W(AW), .REG_W(DW)) bus ();

  reg_bank_arbiter #(.ADDR_W(AW), .REG_W(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model state ----------------
  bit         act;          // a transaction has been granted and not yet completed
  int         g_edge;       // cycle index of the grant edge
  int         n_we;         // number of cycles rb_we stays high
  int         dly;          // bank ack delay in strobe cycles (>= TO means never)
  int         free_edge;    // first edge at which a new grant is possible
  int         own;
  int         last_own;
  bit         t_wr;
  bit         t_err;
  logic [7:0] t_addr, t_wdata, rd_val;
  logic [7:0] mem [256];
  logic [7:0] exp_rdata [2];
  bit         exp_err [2];
  bit         exp_rb_wr;
  logic [7:0] exp_rb_addr, exp_rb_wdata;
  int         txn_cnt = 0;

  // requester stimulus
  bit         pend [2];
  bit         dropped [2];
  bit         s_wr [2];
  logic [7:0] s_addr [2];
  logic [7:0] s_wdata [2];

  // knobs
  int p_req     = 40;
  int ena_pct   = 85;
  int dly_force = -1;
  bit rst_rand  = 1'b0;
  bit force_rst = 1'b0;

  task automatic model_reset(input int first_free);
    act          = 1'b0;
    last_own     = 1;
    exp_rdata[0] = 8'h00;
    exp_rdata[1] = 8'h00;
    exp_err[0]   = 1'b0;
    exp_err[1]   = 1'b0;
    exp_rb_wr    = 1'b0;
    exp_rb_addr  = 8'h00;
    exp_rb_wdata = 8'h00;
    for (int i = 0; i < 2; i++) begin
      pend[i]    = 1'b0;
      dropped[i] = 1'b0;
    end
    free_edge = first_free;
  endtask

  // One clock cycle: check the outputs of the current cycle, then drive the
  // inputs for the next edge and advance the model.
  task automatic step();
    bit         in_acc, in_done, acked, do_rst, r0, r1;
    logic [1:0] onehot;
    int         r;

    in_acc  = act && (cyc >= g_edge) && (cyc < g_edge + n_we);
    in_done = act && (cyc == g_edge + n_we);
    onehot  = (own == 1) ? 2'b10 : 2'b01;

    if (in_done) begin
      acked          = (dly < TO);
      exp_rdata[own] = acked ? (t_wr ? 8'h00 : rd_val) : 8'h00;
      exp_err[own]   = acked ? t_err : 1'b1;
      if (acked && t_wr) mem[t_addr] = t_wdata;
      last_own = own;
    end

    check_eq("gnt",       32'(bus.gnt),       32'((in_acc || in_done) ? onehot : 2'b00));
    check_eq("busy",      32'(bus.busy),      32'(in_acc || in_done));
    check_eq("rb_we",     32'(bus.rb_we),     32'(in_acc));
    check_eq("m0_done",   32'(bus.m0_done),   32'(in_done && own == 0));
    check_eq("m1_done",   32'(bus.m1_done),   32'(in_done && own == 1));
    check_eq("m0_rdata",  32'(bus.m0_rdata),  32'(exp_rdata[0]));
    check_eq("m0_err",    32'(bus.m0_err),    32'(exp_err[0]));
    check_eq("m1_rdata",  32'(bus.m1_rdata),  32'(exp_rdata[1]));
    check_eq("m1_err",    32'(bus.m1_err),    32'(exp_err[1]));
    check_eq("rb_addr",   32'(bus.rb_addr),   32'(exp_rb_addr));
    check_eq("rb_wdata",  32'(bus.rb_wdata),  32'(exp_rb_wdata));
    check_eq("rb_wr_rdn", 32'(bus.rb_wr_rdn), 32'(exp_rb_wr));

    if (in_done) begin
      txn_cnt++;
      $display("txn %0d cyc %0d: m%0d %s addr=%02h wdata=%02h -> rdata=%02h err=%0d strobe_cycles=%0d",
               txn_cnt, cyc, own, t_wr ? "WR" : "RD", t_addr, t_wdata,
               exp_rdata[own], exp_err[own], n_we);
      pend[own]    = 1'b0;
      dropped[own] = 1'b0;
      act          = 1'b0;
    end

    // ---- inputs for the next edge ----
    do_rst = force_rst || (rst_rand && in_acc && $urandom_range(0, 199) == 0);
    if (do_rst) model_reset(cyc + 2);

    for (int i = 0; i < 2; i++) begin
      if (!pend[i] && $urandom_range(0, 99) < p_req) begin
        pend[i]    = 1'b1;
        s_wr[i]    = 1'($urandom_range(0, 1));
        s_addr[i]  = 8'($urandom_range(0, 15));
        s_wdata[i] = 8'($urandom);
      end
      // the owner may drop its request once granted; it must be ignored
      if (act && own == i && g_edge <= cyc && $urandom_range(0, 7) == 0) dropped[i] = 1'b1;
    end
    r0 = pend[0] && !dropped[0];
    r1 = pend[1] && !dropped[1];

    rst           = do_rst;
    bus.ena       = ($urandom_range(0, 99) < ena_pct);
    bus.m0_req    = r0;
    bus.m0_wr_rdn = s_wr[0];
    bus.m0_addr   = s_addr[0];
    bus.m0_wdata  = s_wdata[0];
    bus.m1_req    = r1;
    bus.m1_wr_rdn = s_wr[1];
    bus.m1_addr   = s_addr[1];
    bus.m1_wdata  = s_wdata[1];

    // bank: combinational-style ack in the chosen strobe cycle, junk otherwise
    if (in_acc && dly < TO && cyc == g_edge + dly) begin
      bus.rb_ack   = 1'b1;
      bus.rb_rdata = rd_val;
      bus.rb_err   = t_err;
    end else begin
      bus.rb_ack   = 1'b0;
      bus.rb_rdata = 8'($urandom);
      bus.rb_err   = 1'($urandom_range(0, 1));
    end

    // grant prediction for the next edge
    if (!do_rst && !act && (cyc + 1 >= free_edge) && bus.ena && (r0 || r1)) begin
      own    = (r0 && r1) ? (1 - last_own) : (r1 ? 1 : 0);
      act    = 1'b1;
      g_edge = cyc + 1;
      if (dly_force >= 0) dly = dly_force;
      else begin
        r = $urandom_range(0, 9);
        if (r < 6)      dly = $urandom_range(0, 2);
        else if (r < 8) dly = $urandom_range(3, 20);
        else            dly = 255;
      end
      n_we         = (dly < TO) ? dly + 1 : TO;
      free_edge    = g_edge + n_we + 2;
      t_wr         = s_wr[own];
      t_addr       = s_addr[own];
      t_wdata      = s_wdata[own];
      rd_val       = mem[t_addr];
      t_err        = ($urandom_range(0, 7) == 0);
      exp_rb_wr    = t_wr;
      exp_rb_addr  = t_addr;
      exp_rb_wdata = t_wdata;
    end

    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    bit found;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      s_wr[i]    = 1'b0;
      s_addr[i]  = 8'h00;
      s_wdata[i] = 8'h00;
    end

    rst           = 1'b1;
    bus.ena       = 1'b0;
    bus.m0_req    = 1'b0;
    bus.m0_wr_rdn = 1'b0;
    bus.m0_addr   = '0;
    bus.m0_wdata  = '0;
    bus.m1_req    = 1'b0;
    bus.m1_wr_rdn = 1'b0;
    bus.m1_addr   = '0;
    bus.m1_wdata  = '0;
    bus.rb_rdata  = '0;
    bus.rb_ack    = 1'b0;
    bus.rb_err    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cyc = 0;
    model_reset(1);

    // mixed random traffic, occasional resets during an access
    rst_rand = 1'b1;
    repeat (3000) step();

    // saturated requests with immediate acks: strict alternation, 3-cycle spacing
    rst_rand  = 1'b0;
    p_req     = 100;
    ena_pct   = 100;
    dly_force = 0;
    repeat (120) step();

    // bank never acks: every transaction times out
    dly_force = 255;
    repeat (100) step();

    // directed reset while the strobe is active, then both masters request
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      step();
      if (act && cyc >= g_edge && cyc < g_edge + n_we - 2) found = 1'b1;
    end
    check_eq("rst_window_found", 32'(found), 32'd1);
    force_rst = 1'b1;
    step();
    force_rst = 1'b0;
    dly_force = -1;
    repeat (200) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
Shares one register-bank application interface between two requesters, master 0 and master 1 (e.g. the SPI peripheral and a debug/UART master). Two-way round-robin arbitration; one transaction at a time. Latches the winning request, drives the bank strobe until ack or timeout, and returns rdata/err with a one-cycle done pulse. Sits between the bus masters and the register bank.

Parameters:
ADDR_W, 8, address width
REG_W, 8, data width
TIMEOUT, 15, max strobe cycles without rb_ack before abort (legal range 1..255)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ena  in  1  block enable; low blocks new grants
m0_req  in  1  master 0 request; held high until m0_done
m0_wr_rdn  in  1  1=write, 0=read
m0_addr  in  ADDR_W  address
m0_wdata  in  REG_W  write data
m0_done  out  1  one-cycle completion pulse
m0_rdata  out  REG_W  read data, valid with m0_done
m0_err  out  1  error, valid with m0_done
m1_req, m1_wr_rdn, m1_addr, m1_wdata, m1_done, m1_rdata, m1_err  same as m0_*, for master 1
gnt  out  2  one-hot current owner; 00 when idle
busy  out  1  high in any state other than IDLE
rb_wr_rdn  out  1  to bank
rb_addr  out  ADDR_W  to bank
rb_wdata  out  REG_W  to bank
rb_we  out  1  access strobe, for both reads and writes
rb_rdata  in  REG_W  from bank
rb_ack  in  1  from bank; may be combinational (same cycle as rb_we)
rb_err  in  1  from bank; sampled with rb_ack

Behaviour:
- Reset: state=IDLE, last_gnt=1 (master 0 wins first tie). All outputs 0: gnt, busy, rb_*, m*_done, m*_rdata, m*_err. Timeout counter 0.
- Reset takes priority over everything, including mid-ACCESS. Any in-flight transaction is dropped with no done pulse.
- All outputs are registered.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If ena=1 and any req: choose the winner.
    - Only one req high: that master wins.
    - Both high: the master != last_gnt wins.
  - Latch the winner's wr_rdn/addr/wdata into rb_*. Set gnt, rb_we=1, busy=1. Next state ACCESS.
  - If ena=0: stay in IDLE.
- ACCESS (rb_we=1, rb_* held stable):
  - rb_ack=1: capture rb_rdata and rb_err into the owner's m*_rdata and m*_err. Assert the owner's m*_done. rb_we=0. Next state RESP.
  - rb_ack=0: increment the counter. When the counter reaches TIMEOUT (rb_we has been high for TIMEOUT cycles), abort: rdata=0, err=1, done. Next state RESP.
  - rb_ack on the cycle the counter reaches TIMEOUT: the ack wins (normal completion).
  - ena falling mid-ACCESS has no effect; the transaction completes.
  - req dropping mid-transaction is ignored; the transaction still completes and done is still pulsed.
- RESP:
  - m*_done is high for exactly this one cycle, together with m*_rdata and m*_err.
  - last_gnt <= owner; counter cleared; gnt=00; next state IDLE.
  - req is not sampled in RESP. A req still high in the following IDLE cycle is treated as a new transaction.
- m*_rdata and m*_err hold their values after done until the next completion for that master. m*_rdata is 0 for writes (captured only when rb_wr_rdn=0).
- rb_addr, rb_wdata and rb_wr_rdn hold their last values when idle.
- Latency with rb_ack combinational: req high at edge N (sampled in IDLE) → rb_we high during cycle N+1 → done high during cycle N+2.
- Back-to-back throughput: one transaction per 3 cycles. With both masters requesting continuously, grants strictly alternate.

Test Plan:
- Single write: after reset, m0 write addr=0x12, wdata=0xA5, bank acks immediately → rb_we high 1 cycle with rb_addr=0x12, rb_wdata=0xA5, rb_wr_rdn=1; m0_done 2 cycles after req; m0_err=0; m1_done never pulses.
- Read data path: m1 read addr=0x03, bank returns rdata=0x5C with ack delayed 3 cycles → rb_we high 4 cycles; m1_rdata=0x5C and m1_err=0 with m1_done.
- Simultaneous requests: m0 and m1 held high for 4 transactions → grant order m0, m1, m0, m1; gnt one-hot each time; transactions spaced 3 cycles apart.
- Timeout: bank never acks, TIMEOUT=15 → rb_we high exactly 15 cycles; then m0_done with m0_err=1 and m0_rdata=0; rb_err=1 with ack → passed through as m0_err=1.
- ena gating: ena=0 with m0_req=1 → no rb_we, busy=0; raise ena → grant on the next cycle. Drop ena during ACCESS → transaction still completes with done.
- Reset mid-ACCESS: assert rst while rb_we=1 → next cycle all outputs 0, no done pulse; after release with simultaneous requests, m0 wins.
